// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider slice.
package div_pkg;

   localparam int default_n = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bundle between a requester (master) and the divider (slave).
interface restoring_divider_if
   import div_pkg::*;
#(
   parameter int n = default_n
);

   logic         start;
   logic [n-1:0] dividend;
   logic [n-1:0] divisor;
   logic         busy;
   logic         done;
   logic [n-1:0] quotient;
   logic [n-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/divider_datapath.sv
// A/Q/M registers with the one-bit-per-cycle shift and (n+1)-bit trial subtract.
module divider_datapath #(
   parameter int n = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic [n-1:0] q_val,
   output logic [n-1:0] rem_val
);

   logic        [n:0]   a;
   logic        [n-1:0] q;
   logic        [n-1:0] m;
   logic        [n:0]   a_sh;
   logic signed [n:0]   t;
   logic                borrow;

   assign a_sh = {a[n-1:0], q[n-1]};
   assign t    = signed'(a_sh) - signed'({1'b0, m});
   // a[n] is always clear between steps; folding it in keeps the whole A register observable.
   assign borrow = t[n] & ~a[n];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a <= '0;
         q <= '0;
         m <= '0;
      end else if (load) begin
         a <= '0;
         q <= dividend;
         m <= divisor;
      end else if (step) begin
         a <= borrow ? a_sh : unsigned'(t);
         q <= {q[n-2:0], ~borrow};
      end
   end

   assign q_val   = q;
   assign rem_val = a[n-1:0];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: IDLE/RUN/FINISH control around divider_datapath.
// Optional DIV_ZERO_CHECK_EN short-circuits a zero divisor straight to FINISH.
module restoring_divider
   import div_pkg::*;
#(
   parameter int n = default_n
) (
   input logic                clock,
   input logic                reset,
   restoring_divider_if.slave bus
);

   localparam int cw = $clog2(n + 1);

   state_t        state;
   logic [cw-1:0] count;
   logic          busy_r;
   logic          done_r;
   logic [n-1:0]  quotient_r;
   logic [n-1:0]  remainder_r;
   logic [n-1:0]  q_val;
   logic [n-1:0]  rem_val;
   logic          load;
   logic          step;

   assign load = (state == IDLE) && bus.start;
   assign step = (state == RUN);

   divider_datapath #(.n(n)) u_datapath (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .dividend (bus.dividend),
      .divisor  (bus.divisor),
      .q_val    (q_val),
      .rem_val  (rem_val)
   );

`ifdef DIV_ZERO_CHECK_EN
   logic zero_div;
   logic dbz_r;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
`ifdef DIV_ZERO_CHECK_EN
         zero_div    <= 1'b0;
         dbz_r       <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  count  <= cw'(n);
                  busy_r <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                  zero_div <= (bus.divisor == '0);
                  state    <= (bus.divisor == '0) ? FINISH : RUN;
`else
                  state  <= RUN;
`endif
               end
            end
            RUN: begin
               count <= count - 1'b1;
               if (count == cw'(1)) state <= FINISH;
            end
            FINISH: begin
`ifdef DIV_ZERO_CHECK_EN
               // On the short-circuit path Q still holds the captured dividend.
               quotient_r  <= zero_div ? '1 : q_val;
               remainder_r <= zero_div ? q_val : rem_val;
               dbz_r       <= zero_div;
`else
               quotient_r  <= q_val;
               remainder_r <= rem_val;
`endif
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
`ifdef DIV_ZERO_CHECK_EN
   assign bus.div_by_zero = dbz_r;
`else
   assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (n=8): directed literal cases plus randomized traffic
// checked every cycle against a cycle-level behavioural model of the handshake and results.
module tb_restoring_divider;

   localparam int n = 8;
`ifdef DIV_ZERO_CHECK_EN
   localparam bit dz_en = 1'b1;
`else
   localparam bit dz_en = 1'b0;
`endif

   logic clock;
   logic reset;
   int   n_pass;
   int   n_total;

   restoring_divider_if #(.n(n)) bus ();

   restoring_divider #(.n(n)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else n_pass++;
   endtask

   // Model: results from plain integer division; timing from accept edge plus fixed latency.
   int          cyc;
   bit          inflt;
   int          acc;
   int          lat;
   int          k;
   logic [7:0]  eq, er, oq, orr;
   logic        edz, odz;
   bit          bexp, dexp;

   function automatic int model_lat(input logic [7:0] dv);
      return (dz_en && dv == 8'h00) ? 1 : n + 1;
   endfunction

   initial begin
      cyc = 0; inflt = 0; acc = 0; lat = 0;
      oq = '0; orr = '0; odz = 1'b0; eq = '0; er = '0; edz = 1'b0;
      forever begin
         @(negedge clock);
         bexp = 0;
         dexp = 0;
         if (!reset) begin
            inflt = 0;
            oq = '0; orr = '0; odz = 1'b0;
         end else if (inflt) begin
            k    = cyc - acc;
            bexp = (k < lat);
            dexp = (k == lat);
            if (dexp) begin
               oq = eq; orr = er; odz = edz;
               inflt = 0;
            end
         end
         chk("busy", int'(bus.busy), int'(bexp));
         chk("done", int'(bus.done), int'(dexp));
         chk("quotient", int'(bus.quotient), int'(oq));
         chk("remainder", int'(bus.remainder), int'(orr));
         chk("div_by_zero", int'(bus.div_by_zero), int'(odz));
         if (reset && !inflt && bus.start) begin
            inflt = 1;
            acc   = cyc + 1;
            lat   = model_lat(bus.divisor);
            if (bus.divisor == 8'h00) begin
               eq = 8'hFF;
               er = bus.dividend;
            end else begin
               eq = bus.dividend / bus.divisor;
               er = bus.dividend % bus.divisor;
            end
            edz = dz_en && (bus.divisor == 8'h00);
         end
         cyc++;
      end
   end

   // Drives one operation, optionally holding start high (with scrambled operands) for extra cycles.
   // Returns at posedge+2 of the done cycle, so a following call is back-to-back.
   task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input int hold,
                         output int lat_seen);
      int c;
      bus.dividend = dd;
      bus.divisor  = dv;
      bus.start    = 1'b1;
      @(posedge clock); #2;
      c = 0;
      lat_seen = -1;
      while (c < 60) begin
         if (c < hold) begin
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            lat_seen = c;
            break;
         end
         @(posedge clock); #2;
         c++;
      end
      bus.start = 1'b0;
      if (lat_seen < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic directed(input string nm, input logic [7:0] dd, input logic [7:0] dv,
                           input logic [7:0] xq, input logic [7:0] xr, input bit xdz,
                           input int xlat, input int hold);
      int ls;
      run_op(dd, dv, hold, ls);
      chk({nm, "_latency"}, ls, xlat);
      chk({nm, "_q"}, int'(bus.quotient), int'(xq));
      chk({nm, "_r"}, int'(bus.remainder), int'(xr));
      chk({nm, "_dbz"}, int'(bus.div_by_zero), int'(xdz));
   endtask

   task automatic count_dones(input string nm, input int cycles);
      int cnt;
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock); #2;
         if (bus.done) cnt++;
      end
      chk(nm, cnt, 0);
   endtask

   initial begin
      int         ls;
      int         hold;
      int         gap;
      logic [7:0] dd, dv;
      n_pass = 0;
      n_total = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      repeat (3) @(posedge clock);
      #2;
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_q", int'(bus.quotient), 0);
      chk("reset_r", int'(bus.remainder), 0);
      chk("reset_dbz", int'(bus.div_by_zero), 0);
      reset = 1'b1;
      @(posedge clock); #2;

      directed("e5_07", 8'hE5, 8'h07, 8'h20, 8'h05, 1'b0, 9, 0);
      directed("47_0a", 8'h47, 8'h0A, 8'h07, 8'h01, 1'b0, 9, 0);
      directed("ff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9, 0);
      directed("05_09", 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 9, 0);
      directed("b2b_c8_0d", 8'hC8, 8'h0D, 8'h0F, 8'h05, 1'b0, 9, 0);
      directed("e5_00", 8'hE5, 8'h00, 8'hFF, 8'hE5, dz_en, dz_en ? 1 : 9, 0);
      directed("64_05", 8'h64, 8'h05, 8'h14, 8'h00, 1'b0, 9, 0);
      directed("held_start", 8'h9C, 8'h0B, 8'h0E, 8'h02, 1'b0, 9, 6);
      count_dones("extra_done_after_hold", 12);

      // Abort in cycle 4 of an operation.
      bus.dividend = 8'hE5;
      bus.divisor  = 8'h07;
      bus.start    = 1'b1;
      @(posedge clock); #2;
      bus.start = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_q", int'(bus.quotient), 0);
      chk("abort_r", int'(bus.remainder), 0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      count_dones("done_after_abort", 12);
      directed("post_reset", 8'h47, 8'h0A, 8'h07, 8'h01, 1'b0, 9, 0);

      for (int i = 0; i < 250; i++) begin
         dd = 8'($urandom);
         case ($urandom_range(0, 9))
            0:       dv = 8'h00;
            1, 2, 3: dv = 8'($urandom_range(1, 15));
            default: dv = 8'($urandom);
         endcase
         hold = (dz_en && dv == 8'h00) ? 0 : $urandom_range(0, 4);
         run_op(dd, dv, hold, ls);
         chk("rand_latency", ls, model_lat(dv));
         gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) begin
            @(posedge clock); #2;
         end
      end

      repeat (3) @(posedge clock);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 Parameter: n, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  n  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  n  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high from the edge after accepting start until the operation completes.
REQ-008 done  output  1  single-cycle pulse; results are valid.
REQ-009 quotient  output  n  registered quotient.
REQ-010 remainder  output  n  registered remainder.
REQ-011 div_by_zero  output  1  registered flag for a zero divisor.

Function
REQ-012 FSM states SHALL be IDLE, RUN and FINISH; there are no other reachable states.
REQ-013 IDLE with start=1: load A (n+1 bits)=0, Q=dividend, M=divisor and count=n, then go to RUN.
REQ-014 IDLE with start=0: hold all registers.
REQ-015 Each RUN cycle: shift {A,Q} left by 1, with A receiving the MSB of Q.
REQ-016 In the same cycle, form T=A-{0,M}; if T>=0, A=T and Q[0]=1; otherwise restore A and set Q[0]=0.
REQ-017 In the same cycle, decrement count.
REQ-018 RUN SHALL transition to FINISH on the cycle where count reaches 0, after exactly n RUN cycles.
REQ-019 FINISH: quotient=Q, remainder=A[n-1:0], done=1 for exactly one cycle, then go to IDLE.
REQ-020 Latency: done SHALL be high in clock cycle n+1 after the edge that accepted start.
REQ-021 busy SHALL be high in RUN and FINISH, and low in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values until the next FINISH.
REQ-024 Subtraction SHALL use n+1 bits; the sign of T is the borrow.
REQ-025 There SHALL be no overflow for any n-bit unsigned operands.
REQ-026 divisor=0 with the algorithm run to completion yields quotient all ones and remainder=dividend.
REQ-027 A new start SHALL be accepted in the cycle immediately after FINISH, i.e. back-to-back operations.

Reset
REQ-028 While reset=0: state=IDLE, and A, Q, M, count, quotient, remainder all zero.
REQ-029 While reset=0: busy=0, done=0, div_by_zero=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse.
REQ-031 After reset deassertion, the first start SHALL be accepted normally.

Configuration
REQ-032 Macro DIV_ZERO_CHECK_EN defined: on accepting start with divisor=0, go directly from IDLE to FINISH.
REQ-033 In that case FINISH outputs quotient all ones, remainder=dividend and div_by_zero=1; done is high in cycle 1 after acceptance.
REQ-034 With DIV_ZERO_CHECK_EN defined, div_by_zero SHALL be cleared at every FINISH that has a nonzero divisor.
REQ-035 Macro not defined: a zero divisor runs the normal n-cycle algorithm (REQ-026) and div_by_zero is tied to 0.

Structure
REQ-036 Package div_pkg SHALL hold the state enum typedef (IDLE/RUN/FINISH) and the default width constant 8.
REQ-037 Sub-module divider_datapath SHALL hold the A/Q/M registers, shifter and trial subtractor.
REQ-038 divider_datapath SHALL be controlled by load and step signals from the FSM in restoring_divider.
REQ-039 count SHALL be $clog2(n+1) bits.

Verification (n=8, 10 ns clock)
REQ-040 dividend=0xE5, divisor=0x07, start pulse -> done in cycle 9, quotient=0x20, remainder=0x05.
REQ-041 dividend=0x47, divisor=0x0A -> quotient=0x07, remainder=0x01; 0xFF/0x01 -> quotient=0xFF, remainder=0x00.
REQ-042 dividend=0x05, divisor=0x09 -> quotient=0x00, remainder=0x05; second start in cycle after done -> accepted, correct result.
REQ-043 dividend=0xE5, divisor=0x00 -> with macro: done in cycle 1, quotient=0xFF, remainder=0xE5, div_by_zero=1.
REQ-044 Same zero-divisor stimulus without macro -> done in cycle 9, same quotient and remainder, div_by_zero=0.
REQ-045 start held high during RUN -> exactly one done per accepted start; reset=0 in cycle 4 -> busy=0, no done, outputs zero.
